restador_serial_4: RTL and testbench
====================================

# restador_serial_4

Bit-serial 4-bit subtractor with start/done handshake. It computes A_num − B_num − borrow_in one bit per clock, LSB first, through a single full-subtractor cell. It is the subtraction counterpart to the team's ripple-carry adder and is used by datapath blocks that need a low-area, multicycle difference with borrow and signed-overflow flags.

## Interface
- N, default 4: operand width. The counter index is $clog2(N) bits wide.
- clk  input  1  system clock; rising edge active
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- A_num  input  [N-1:0]  minuend; latched when start is accepted
- B_num  input  [N-1:0]  subtrahend; latched when start is accepted
- borrow_in  input  1  initial borrow; latched when start is accepted
- busy  output  1  high while in SHIFT
- done  output  1  single-cycle pulse; result and flags are valid
- result  output  [N-1:0]  difference modulo 2^N
- borrow_out  output  1  final borrow; 1 when the unsigned A < B + borrow_in
- overflow  output  1  two's-complement overflow of the signed subtraction

## Operation
- States:
  - IDLE: start=1 → SHIFT. Latch A, B and borrow_in; idx=0; clear the result register.
  - SHIFT: each edge computes one bit: d = a[idx]^b[idx]^br; br' = (~a[idx]&b[idx]) | (~(a[idx]^b[idx])&br). Write result[idx]=d, set br=br', idx++. When idx=N-1 the state moves to DONE.
  - DONE: done=1 for exactly one cycle. Next state is IDLE, or SHIFT if start=1, which accepts a new operation back-to-back with a fresh latch.
- Flags are computed at the final SHIFT edge:
  - borrow_out = br' of bit N-1
  - overflow = (A[N-1]^B[N-1]) & (A[N-1]^result[N-1])
- result, borrow_out and overflow hold their values after DONE until the next accepted start. They are cleared on acceptance.
- start in SHIFT is ignored. No queuing, and the operands in flight are unaffected.
- Input changes on A_num, B_num and borrow_in after acceptance have no effect.

## Timing
- Reset values: state=IDLE, busy=0, done=0, result=0, borrow_out=0, overflow=0, idx=0, br=0.
- Reset takes priority over everything. Asserted mid-SHIFT, it abandons the operation and no done pulse follows.
- Start accepted at edge T0. busy is high for the N cycles following T0. Bits 0..N-1 are written at edges T1..TN.
- done is high in the cycle after edge TN, for exactly one cycle. Latency for N=4 is 5 cycles from the start edge to the end of the done cycle.
- Back-to-back start in DONE gives a throughput of one result every N+1 cycles.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package restador_pkg holds:
  - the state enum {IDLE, SHIFT, DONE}
  - localparam N_DEFAULT=4
- Sub-module restador_1 is a combinational 1-bit full subtractor.
  - Ports: A_num, B_num, borrow_in, result, borrow_out.
  - It is instantiated once and fed from the indexed operand bits.
- Top-level registers: operand A and B, br, idx, result, flags, state.

## Test plan
- A=7, B=3, borrow_in=0, start → done 4 cycles after the start edge; result=4, borrow_out=0, overflow=0; busy high exactly 4 cycles.
- A=3, B=7, borrow_in=0 → result=12, borrow_out=1, overflow=0.
- A=0, B=0, borrow_in=1 → result=15, borrow_out=1, overflow=0.
- A=7, B=8 (−8) → result=15, borrow_out=1, overflow=1. Then A=8, B=1 → result=7, overflow=1, borrow_out=0.
- Handshake and reset behaviour:
  - Start with A=5, B=2; pulse start again with A=1, B=1 during SHIFT. Required: result=3, one done pulse only.
  - Assert rst in the 2nd SHIFT cycle. Required: all outputs 0, no done pulse.
- Back-to-back: start held high through DONE with A=9, B=4, then A=2, B=6. Required: done pulses 5 cycles apart; result=5 then result=12 with borrow_out=1.

Source files
------------

// File: rtl/restador_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package restador_pkg;
  localparam int N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;
endpackage

// File: rtl/restador_1.sv
// purpose: combinational 1-bit full subtractor (a - b - borrow)
// latency: none, pure combinational
// backpressure: none, no handshake
module restador_1 (
  input  logic A_num,
  input  logic B_num,
  input  logic borrow_in,
  output logic result,
  output logic borrow_out
);
  assign result     = A_num ^ B_num ^ borrow_in;
  assign borrow_out = (~A_num & B_num) | (~(A_num ^ B_num) & borrow_in);
endmodule

// File: rtl/restador_serial_4.sv
// purpose: bit-serial N-bit subtractor A - B - borrow_in, LSB first, one bit per clock
// latency: done pulses N cycles after the start edge; one result every N+1 cycles back-to-back
// backpressure: start only accepted in IDLE or DONE; start during SHIFT is dropped, not queued
module restador_serial_4
  import restador_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A_num,
  input  logic [N-1:0] B_num,
  input  logic         borrow_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         borrow_out,
  output logic         overflow
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, b_q, result_q;
  logic [IW-1:0]  idx_q;
  logic           br_q, borrow_out_q, overflow_q;
  logic           accept;
  logic           bit_d, bit_br;

  restador_1 u_cell (
    .A_num      (a_q[idx_q]),
    .B_num      (b_q[idx_q]),
    .borrow_in  (br_q),
    .result     (bit_d),
    .borrow_out (bit_br)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        accept = start;
        if (start) state_d = SHIFT;
      end
      SHIFT: begin
        if (idx_q == LAST) state_d = DONE;
      end
      DONE: begin
        accept  = start;
        state_d = start ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  // Datapath: operands frozen at acceptance, one result bit per SHIFT edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      br_q         <= 1'b0;
      idx_q        <= '0;
      result_q     <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (accept) begin
      a_q          <= A_num;
      b_q          <= B_num;
      br_q         <= borrow_in;
      idx_q        <= '0;
      result_q     <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (state_q == SHIFT) begin
      result_q[idx_q] <= bit_d;
      br_q            <= bit_br;
      idx_q           <= idx_q + IW'(1);
      if (idx_q == LAST) begin
        borrow_out_q <= bit_br;
        overflow_q   <= (a_q[N-1] ^ b_q[N-1]) & (a_q[N-1] ^ bit_d);
      end
    end
  end

  assign result     = result_q;
  assign borrow_out = borrow_out_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_restador_serial_4.sv
// Bench for restador_serial_4: directed cases, handshake/reset scenarios and random ops vs an arithmetic model.
module tb_restador_serial_4;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst, start, borrow_in;
  logic [N-1:0] A_num, B_num;
  logic         busy, done, borrow_out, overflow;
  logic [N-1:0] result;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  restador_serial_4 #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .A_num      (A_num),
    .B_num      (B_num),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: unsigned difference, unsigned borrow, signed range overflow.
  function automatic void model(input int a, input int b, input int c,
                                output logic [N-1:0] r, output logic bo, output logic ov);
    int sa, sb, d;
    r  = N'((a - b - c) & ((1 << N) - 1));
    bo = (a < b + c);
    sa = (a >= (1 << (N - 1))) ? a - (1 << N) : a;
    sb = (b >= (1 << (N - 1))) ? b - (1 << N) : b;
    d  = sa - sb - c;
    ov = (d > (1 << (N - 1)) - 1) || (d < -(1 << (N - 1)));
  endfunction

  // One accepted operation; inputs are scrambled right after acceptance.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                        output int lat, output int bcnt, output logic [N-1:0] r,
                        output logic bo, output logic ov, output logic one_pulse,
                        output logic held);
    @(negedge clk);
    A_num = a; B_num = b; borrow_in = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A_num = N'($urandom); B_num = N'($urandom); borrow_in = 1'($urandom);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
    r = result; bo = borrow_out; ov = overflow;
    @(negedge clk);
    one_pulse = !done;
    held      = (result === r) && (borrow_out === bo) && (overflow === ov);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A_num = '0; B_num = '0; borrow_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy, done, result, borrow_out, overflow} !== '0) begin
      n_miss++;
      $display("FAIL reset_state: got busy=%b done=%b result=%0d bo=%b ov=%b, want all 0",
               busy, done, result, borrow_out, overflow);
    end
  endtask

  task automatic test_directed();
    int ta[5] = '{7, 3, 0, 7, 8};
    int tb[5] = '{3, 7, 0, 8, 1};
    int tc[5] = '{0, 0, 1, 0, 0};
    int er[5] = '{4, 12, 15, 15, 7};
    int eb[5] = '{0, 1, 1, 1, 0};
    int eo[5] = '{0, 0, 0, 1, 1};
    int lat, bcnt;
    logic [N-1:0] r;
    logic bo, ov, one, held;
    for (int i = 0; i < 5; i++) begin
      run_op(N'(ta[i]), N'(tb[i]), 1'(tc[i]), lat, bcnt, r, bo, ov, one, held);
      n_vec++;
      if (r !== N'(er[i]) || bo !== 1'(eb[i]) || ov !== 1'(eo[i])) begin
        n_miss++;
        $display("FAIL directed_%0d: got r=%0d bo=%b ov=%b, want r=%0d bo=%0d ov=%0d",
                 i, r, bo, ov, er[i], eb[i], eo[i]);
      end
      n_vec++;
      if (lat !== N || bcnt !== N) begin
        n_miss++;
        $display("FAIL directed_timing_%0d: got latency=%0d busy_cycles=%0d, want %0d/%0d",
                 i, lat, bcnt, N, N);
      end
      n_vec++;
      if (!one || !held) begin
        n_miss++;
        $display("FAIL directed_pulse_hold_%0d: got single_pulse=%b held=%b, want 1/1", i, one, held);
      end
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    logic [N-1:0] r = '0;
    @(negedge clk);
    A_num = 4'd5; B_num = 4'd2; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; A_num = 4'd1; B_num = 4'd1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done) begin pulses++; r = result; end
      @(negedge clk);
    end
    n_vec++;
    if (pulses !== 1 || r !== 4'd3) begin
      n_miss++;
      $display("FAIL ignore_start: got pulses=%0d result=%0d, want pulses=1 result=3", pulses, r);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    @(negedge clk);
    A_num = 4'd15; B_num = 4'd0; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_vec++;
    if (result !== 4'd1 || busy !== 1'b1) begin
      n_miss++;
      $display("FAIL reset_mid_pre: got result=%0d busy=%b, want result=1 busy=1", result, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({busy, done, result, borrow_out, overflow} !== '0) begin
      n_miss++;
      $display("FAIL reset_mid_clear: got busy=%b done=%b result=%0d bo=%b ov=%b, want all 0",
               busy, done, result, borrow_out, overflow);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin
      n_miss++;
      $display("FAIL reset_mid_no_done: got %0d done pulses, want 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    int c1 = 0, c2 = 0, w;
    logic [N-1:0] r1 = '0, r2 = '0;
    logic bo2 = 1'b0;
    @(negedge clk);
    A_num = 4'd9; B_num = 4'd4; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    A_num = 4'd2; B_num = 4'd6;
    w = 0;
    while (!done && w < 20) begin @(negedge clk); w++; end
    c1 = cyc; r1 = result;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!done && w < 20) begin @(negedge clk); w++; end
    c2 = cyc; r2 = result; bo2 = borrow_out;
    n_vec++;
    if (c2 - c1 !== N + 1) begin
      n_miss++;
      $display("FAIL b2b_spacing: got %0d cycles between done pulses, want %0d", c2 - c1, N + 1);
    end
    n_vec++;
    if (r1 !== 4'd5 || r2 !== 4'd12 || bo2 !== 1'b1) begin
      n_miss++;
      $display("FAIL b2b_results: got r1=%0d r2=%0d bo2=%b, want 5/12/1", r1, r2, bo2);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, bcnt, a, b, c;
    logic [N-1:0] r, er;
    logic bo, ov, one, held, ebo, eov;
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, (1 << N) - 1));
      b = int'($urandom_range(0, (1 << N) - 1));
      c = int'($urandom_range(0, 1));
      model(a, b, c, er, ebo, eov);
      run_op(N'(a), N'(b), 1'(c), lat, bcnt, r, bo, ov, one, held);
      n_vec++;
      if (r !== er || bo !== ebo || ov !== eov || lat !== N || !one) begin
        n_miss++;
        $display("FAIL random_%0d (%0d-%0d-%0d): got r=%0d bo=%b ov=%b lat=%0d pulse=%b, want r=%0d bo=%b ov=%b lat=%0d pulse=1",
                 i, a, b, c, r, bo, ov, lat, one, er, ebo, eov, N);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
